// File: rtl/imm_gen_stage_pkg.sv
// Shared RV32I/RV64I opcode constants and the immediate-format tag used by the
// immediate generator stage and its decoder.
package imm_gen_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSVD = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: raw instruction -> extended immediate,
// format tag and illegal-opcode flag.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit EN_RV64_OPS = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    // Signed field views; a size cast of a signed value sign-extends to XLEN.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                fmt = FMT_I;
                imm = XLEN'(imm_i);
            end
            OP_SYSTEM: begin
                // funct3[2] selects the immediate CSR forms carrying a 5-bit uimm
                if (instr[14]) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'(imm_i);
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = XLEN'(imm_s);
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(imm_b);
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(imm_u);
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = XLEN'(imm_j);
            end
            OP_REG: begin
                illegal = 1'b0;
            end
            OP_REG32: begin
                illegal = !EN_RV64_OPS;
            end
            OP_IMM32: begin
                if (EN_RV64_OPS) begin
                    fmt = FMT_I;
                    imm = XLEN'(imm_i);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decodes each instruction and registers it
// behind a two-entry (main + skid) buffer so the stage tolerates stall and flush.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 8,
    parameter bit EN_RV64_OPS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (EN_RV64_OPS && XLEN != 64) begin : g_bad_rv64
        $error("imm_gen_stage: EN_RV64_OPS requires XLEN=64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          dec_entry;
    entry_t          main_q;
    entry_t          skid_q;
    logic            main_valid;
    logic            skid_valid;
    logic            accept;

    imm_decode #(
        .XLEN        (XLEN),
        .EN_RV64_OPS (EN_RV64_OPS)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal,
                      instr: in_instr, tag: in_tag};
    end

    // Handshake: a transfer happens on any edge where valid && ready on that side.
    // in_ready depends only on the skid register, never on out_ready, so the
    // upstream ready path is cut; the skid slot absorbs the one entry that can
    // arrive while the consumer stalls.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            // Main slot frees up: the older skid entry always goes first.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec_entry;
                end
            end
        end else if (accept) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_instr   = main_q.instr;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit and a 64-bit (RV64 ops on) instance share
// one input stream and are compared against a queue-based reference model.
module tb_imm_gen_stage;

    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready_a,  in_ready_b;
    logic             out_valid_a, out_valid_b;
    logic [31:0]      out_imm_a;
    logic [63:0]      out_imm_b;
    logic [2:0]       out_fmt_a,   out_fmt_b;
    logic             out_ill_a,   out_ill_b;
    logic [31:0]      out_instr_a, out_instr_b;
    logic [TAG_W-1:0] out_tag_a,   out_tag_b;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W), .EN_RV64_OPS(1'b0)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_illegal(out_ill_a), .out_instr(out_instr_a),
        .out_tag(out_tag_a)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W), .EN_RV64_OPS(1'b1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_illegal(out_ill_b), .out_instr(out_instr_b),
        .out_tag(out_tag_b)
    );

    int checks = 0;
    int errors = 0;
    logic [TAG_W+31:0] exp_q[$];
    bit zero_data = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Two's-complement interpretation of a 'bits'-wide field.
    function automatic longint sx(input longint raw, input int bits);
        if (raw[bits-1]) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                fmt = 3'd1; v = sx(longint'(ins[31:20]), 12);
            end
            7'b1110011: begin
                if (ins[14]) begin fmt = 3'd6; v = longint'(ins[19:15]); end
                else begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
            end
            7'b0100011: begin
                fmt = 3'd2; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            end
            7'b1100011: begin
                fmt = 3'd3;
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                       longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4; v = sx(longint'(ins[31:12]) * 4096, 32);
            end
            7'b1101111: begin
                fmt = 3'd5;
                v = sx(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12) +
                       longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2, 21);
            end
            7'b0110011: ill = 1'b0;
            7'b0111011: ill = !rv64;
            7'b0011011: begin
                if (rv64) begin fmt = 3'd1; v = sx(longint'(ins[31:20]), 12); end
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 15))
            0:  r[6:0] = 7'b0000011;
            1:  r[6:0] = 7'b0010011;
            2:  r[6:0] = 7'b0011011;
            3:  r[6:0] = 7'b0100011;
            4:  r[6:0] = 7'b1100011;
            5:  r[6:0] = 7'b0110111;
            6:  r[6:0] = 7'b0010111;
            7:  r[6:0] = 7'b1101111;
            8:  r[6:0] = 7'b1100111;
            9:  r[6:0] = 7'b0001111;
            10: r[6:0] = 7'b1110011;
            11: r[6:0] = 7'b0110011;
            12: r[6:0] = 7'b0111011;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_outputs();
        logic [63:0]      imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [31:0]      ins;
        logic [TAG_W-1:0] tg;
        check("in_ready_32", in_ready_a, exp_q.size() < 2);
        check("in_ready_64", in_ready_b, exp_q.size() < 2);
        check("out_valid_32", out_valid_a, exp_q.size() > 0);
        check("out_valid_64", out_valid_b, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            {tg, ins} = exp_q[0];
            check("instr_32", out_instr_a, ins);
            check("tag_32", out_tag_a, tg);
            check("instr_64", out_instr_b, ins);
            check("tag_64", out_tag_b, tg);
            ref_decode(ins, 1'b0, imm, fmt, ill);
            check("imm_32", out_imm_a, imm[31:0]);
            check("fmt_32", out_fmt_a, fmt);
            check("illegal_32", out_ill_a, ill);
            ref_decode(ins, 1'b1, imm, fmt, ill);
            check("imm_64", out_imm_b, imm);
            check("fmt_64", out_fmt_b, fmt);
            check("illegal_64", out_ill_b, ill);
        end else if (zero_data) begin
            check("rst_data_32", {out_imm_a, out_fmt_a, out_ill_a, out_instr_a, out_tag_a}, 64'd0);
            check("rst_imm_64", out_imm_b, 64'd0);
            check("rst_data_64", {out_fmt_b, out_ill_b, out_instr_b, out_tag_b}, 64'd0);
        end
    endtask

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit acc;
        bit fire;
        @(negedge clk);
        check_outputs();
        acc  = in_valid && (exp_q.size() < 2);
        fire = (exp_q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            zero_data = 1'b1;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({in_tag, in_instr});
                zero_data = 1'b0;
            end
        end
        #1;
    endtask

    logic [31:0] d_instr [5];
    logic [31:0] d_imm   [5];
    logic [2:0]  d_fmt   [5];
    logic        d_ill   [5];

    initial begin
        d_instr = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'h300FD073, 32'hFFFFFFFF};
        d_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F, 32'h00000000};
        d_fmt   = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd0};
        d_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        zero_data = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Directed decode vectors, back-to-back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = d_instr[i]; in_tag = TAG_W'(i + 1);
            step();
            check("dir_valid", out_valid_a, 1'b1);
            check("dir_imm", out_imm_a, d_imm[i]);
            check("dir_fmt", out_fmt_a, d_fmt[i]);
            check("dir_illegal", out_ill_a, d_ill[i]);
        end
        in_instr = 32'h800002B7;
        step();
        check("lui64_imm", out_imm_b, 64'hFFFFFFFF80000000);
        check("lui64_fmt", out_fmt_b, 3'd4);
        in_valid = 1'b0;
        step();
        step();

        // Backpressure: tags 1,2 accepted, 3 held until the skid drains
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 8'd1; in_instr = rand_instr();
        step();
        in_tag = 8'd2; in_instr = rand_instr();
        step();
        check("bp_in_ready", in_ready_a, 1'b0);
        in_tag = 8'd3; in_instr = rand_instr();
        step();
        step();
        check("bp_hold_tag", out_tag_a, 8'd1);
        out_ready = 1'b1;
        step();
        check("bp_tag2", out_tag_a, 8'd2);
        check("bp_ready_again", in_ready_a, 1'b1);
        step();
        check("bp_tag3", out_tag_a, 8'd3);
        check("bp_no_bubble", out_valid_a, 1'b1);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid_a, 1'b0);

        // Flush with both slots full and a new input offered
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin in_instr = rand_instr(); in_tag = 8'($urandom); step(); end
        flush = 1'b1; in_instr = rand_instr();
        step();
        check("flush_out_valid", out_valid_a, 1'b0);
        check("flush_in_ready", in_ready_b, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // Reset mid-stream with the consumer stalled
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin in_instr = rand_instr(); in_tag = 8'($urandom); step(); end
        rst = 1'b1;
        step();
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_in_ready", in_ready_a, 1'b1);
        check("rst_imm", out_imm_b, 64'd0);
        check("rst_instr", out_instr_a, 32'd0);
        rst = 1'b0; in_instr = 32'hFFF00093; in_tag = 8'h5A;
        step();
        check("post_rst_valid", out_valid_a, 1'b1);
        check("post_rst_tag", out_tag_a, 8'h5A);
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Randomized traffic with occasional flush
        repeat (1500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_instr  = rand_instr();
            in_tag    = 8'($urandom);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
